// File: rtl/delay_timer_pkg.sv
// rtl/delay_timer_pkg.sv - shared state type and default parameters for the delay timer
package delay_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 1;

endpackage

// File: rtl/delay_timer_tick_gen.sv
// rtl/delay_timer_tick_gen.sv - prescaler producing one tick every PRESCALE enabled cycles
module tick_gen
  import delay_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // With PRESCALE=1 LAST is 0, the counter never leaves 0 and tick follows enable.
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/delay_timer.sv
// rtl/delay_timer.sv - one-shot / auto-reload delay timer with abort and retrigger
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] delay_len,
  input  logic             periodic,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             delay_done
);

  state_t           state_q;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] q_q;
  logic             mode_q;
  logic             done_q;
  logic             run;
  logic             tick;
  logic [WIDTH:0]   q_inc;
  logic             expire;

  assign run    = (state_q == RUN);
  assign q_inc  = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
  assign expire = (q_inc == {1'b0, len_q});

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start | abort),
    .enable(run),
    .tick  (tick)
  );

  // Priority: abort, then start (retrigger swallows a coinciding expiry), then tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      q_q     <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        q_q     <= '0;
      end else if (start) begin
        state_q <= RUN;
        q_q     <= '0;
        len_q   <= (delay_len == '0) ? WIDTH'(1) : delay_len;
        mode_q  <= periodic;
      end else if (run && tick) begin
        if (expire) begin
          q_q    <= '0;
          done_q <= 1'b1;
          if (!mode_q) state_q <= IDLE;
        end else begin
          q_q <= q_inc[WIDTH-1:0];
        end
      end
    end
  end

  assign q          = q_q;
  assign busy       = run;
  assign delay_done = done_q;

endmodule

// File: tb/tb_delay_timer.sv
// tb/tb_delay_timer.sv - scoreboard bench for delay_timer at PRESCALE 1 and 4
module tb_delay_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, periodic_a, abort_a;
  logic [7:0] len_a, q_a;
  logic       busy_a, done_a;
  logic       start_b, periodic_b, abort_b;
  logic [7:0] len_b, q_b;
  logic       busy_b, done_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_a[$];
  int exp_b[$];
  int s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  delay_timer #(.WIDTH(8), .PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .delay_len(len_a), .periodic(periodic_a),
    .abort(abort_a), .q(q_a), .busy(busy_a), .delay_done(done_a)
  );

  delay_timer #(.WIDTH(8), .PRESCALE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .delay_len(len_b), .periodic(periodic_b),
    .abort(abort_b), .q(q_b), .busy(busy_b), .delay_done(done_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: each pulse must match the oldest expected edge; overdue entries are misses.
  always @(negedge clk) begin
    while (exp_a.size() > 0 && exp_a[0] < cyc) begin
      chk("a_missing_done", 0, exp_a[0]);
      void'(exp_a.pop_front());
    end
    if (done_a) begin
      if (exp_a.size() == 0) chk("a_unexpected_done", cyc, -1);
      else chk("a_done_edge", cyc, exp_a.pop_front());
    end
    while (exp_b.size() > 0 && exp_b[0] < cyc) begin
      chk("b_missing_done", 0, exp_b[0]);
      void'(exp_b.pop_front());
    end
    if (done_b) begin
      if (exp_b.size() == 0) chk("b_unexpected_done", cyc, -1);
      else chk("b_done_edge", cyc, exp_b.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    start_a = 0; periodic_a = 0; abort_a = 0; len_a = 0;
    start_b = 0; periodic_b = 0; abort_b = 0; len_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_q", q_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    rst_n = 1'b1;

    // One-shot len=5
    @(negedge clk);
    start_a = 1; len_a = 5; periodic_a = 0; s = cyc + 1; exp_a.push_back(s + 5);
    @(negedge clk); start_a = 0;
    for (int i = 0; i < 5; i++) begin
      chk("os5_q", q_a, i);
      chk("os5_busy", busy_a, 1);
      @(negedge clk);
    end
    chk("os5_end_busy", busy_a, 0);
    chk("os5_end_q", q_a, 0);

    // Retrigger: len=6 restarted after edge 3 with len=2
    @(negedge clk);
    start_a = 1; len_a = 6; s = cyc + 1;
    @(negedge clk); start_a = 0;
    @(negedge clk);
    @(negedge clk); start_a = 1; len_a = 2; exp_a.push_back(s + 5);
    @(negedge clk); start_a = 0;
    chk("retrig_q", q_a, 0);
    repeat (5) @(negedge clk);
    chk("retrig_idle", busy_a, 0);

    // len=0 behaves as len=1, then abort+start together in IDLE
    start_a = 1; len_a = 0; s = cyc + 1; exp_a.push_back(s + 1);
    @(negedge clk); start_a = 0;
    chk("len0_busy", busy_a, 1);
    @(negedge clk);
    chk("len0_end_busy", busy_a, 0);
    start_a = 1; abort_a = 1; len_a = 7;
    @(negedge clk); start_a = 0; abort_a = 0;
    chk("abort_start_idle_busy", busy_a, 0);
    chk("abort_start_idle_q", q_a, 0);

    // Asynchronous reset mid-run, len=10
    @(negedge clk);
    start_a = 1; len_a = 10;
    @(negedge clk); start_a = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_q", q_a, 4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", q_a, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_done", done_a, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy_a, 0);

    // Periodic len=1 at PRESCALE=1: pulse every cycle, abort stops it
    start_a = 1; len_a = 1; periodic_a = 1; s = cyc + 1;
    for (int i = 1; i <= 6; i++) exp_a.push_back(s + i);
    @(negedge clk); start_a = 0; periodic_a = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("p1_q", q_a, 0);
      chk("p1_busy", busy_a, 1);
      chk("p1_done", done_a, 1);
    end
    abort_a = 1;
    @(negedge clk); abort_a = 0;
    chk("p1_abort_busy", busy_a, 0);
    repeat (3) @(negedge clk);

    // PRESCALE=4 periodic len=3, abort at edge 30
    start_b = 1; len_b = 3; periodic_b = 1; s = cyc + 1;
    exp_b.push_back(s + 12); exp_b.push_back(s + 24);
    @(negedge clk); start_b = 0; periodic_b = 0;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (k == 4)  chk("b_q_edge4", q_b, 1);
      if (k == 8)  chk("b_q_edge8", q_b, 2);
      if (k == 12) chk("b_q_edge12", q_b, 0);
      if (k == 25) chk("b_busy_edge25", busy_b, 1);
    end
    abort_b = 1;
    @(negedge clk); abort_b = 0;
    chk("b_abort_busy", busy_b, 0);
    chk("b_abort_q", q_b, 0);
    repeat (15) @(negedge clk);

    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
